// File: rtl/fixed_pkg.sv
// Shared Q10.10 constants and FSM encoding for the fixed-point power/root blocks.
package fixed_pkg;

    localparam int          FRAC_BITS = 10;
    localparam logic [19:0] Q_ONE     = 20'h00400;
    localparam logic [19:0] Q_MAX     = 20'hFFFFF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage

// File: rtl/fx_mul_q10.sv
// Unsigned fixed-point multiply: truncates the fraction and saturates to all-ones
// when the integer part no longer fits.
module fx_mul_q10 #(
    parameter int INT_BITS  = 10,
    parameter int FRAC_BITS = 10,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] p,
    output logic         sat
);

    logic [2*W-1:0] prod;

    assign prod = a * b;
    assign sat  = (prod >> FRAC_BITS) >= ((2*W)'(1) << W);
    assign p    = sat ? {W{1'b1}} : W'(prod >> FRAC_BITS);

endmodule

// File: rtl/fixed_power.sv
// base^n for an unsigned fixed-point base and small integer exponent, one
// multiply per cycle through a single shared multiplier.
module fixed_power
    import fixed_pkg::state_t, fixed_pkg::ST_IDLE, fixed_pkg::ST_CALC, fixed_pkg::ST_OUT;
#(
    parameter int INT_BITS  = 10,
    parameter int FRAC_BITS = 10,
    parameter int EXP_W     = 3,
    localparam int W        = INT_BITS + FRAC_BITS
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [W-1:0]     in_data_1,
    input  logic [EXP_W-1:0] in_data_2,
    output logic             out_valid,
    output logic [W-1:0]     out_data,
    output logic             out_ovf
);

    localparam logic [W-1:0] ONE = W'(1) << FRAC_BITS;

    state_t             state_q, state_d;
    logic [W-1:0]       acc_q, acc_d;
    logic [W-1:0]       base_q, base_d;
    logic [EXP_W-1:0]   cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               out_valid_q, out_valid_d;
    logic [W-1:0]       out_data_q, out_data_d;
    logic               out_ovf_q, out_ovf_d;

    logic [W-1:0]       mul_p;
    logic               mul_sat;

    fx_mul_q10 #(
        .INT_BITS  (INT_BITS),
        .FRAC_BITS (FRAC_BITS)
    ) u_mul (
        .a   (acc_q),
        .b   (base_q),
        .p   (mul_p),
        .sat (mul_sat)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        out_valid_d = 1'b0;
        out_data_d  = '0;
        out_ovf_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    base_d  = in_data_1;
                    acc_d   = (in_data_2 == '0) ? ONE : in_data_1;
                    cnt_d   = in_data_2;
                    ovf_d   = 1'b0;
                    state_d = (in_data_2 <= EXP_W'(1)) ? ST_OUT : ST_CALC;
                end
            end
            ST_CALC: begin
                // Saturation is sticky: a saturated accumulator times a base
                // below 1.0 must not fall back into range.
                acc_d = ovf_q ? {W{1'b1}} : mul_p;
                ovf_d = ovf_q | mul_sat;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == EXP_W'(2)) state_d = ST_OUT;
            end
            ST_OUT: begin
                out_valid_d = 1'b1;
                out_data_d  = acc_q;
                out_ovf_d   = ovf_q;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ovf_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_ovf_q   <= out_ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;

endmodule
